class_vote_filter: RTL

//  Temporal majority filter placed directly downstream of the decision-tree classifier.

---
 rtl/class_vote_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/class_vote_filter.sv
// Temporal majority filter for the classifier output: keeps the last WINDOW class codes
// and reports the most frequent class, with hysteresis so that ties do not make the output flicker.
module class_vote_filter #(
  parameter int WINDOW    = 8,
  parameter int CNT_W     = 4,
  parameter int MIN_VOTES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [2:0]       class_in,
  input  logic             class_valid,
  output logic             in_ready,
  output logic [2:0]       voted_class,
  output logic [CNT_W-1:0] vote_count,
  output logic             confident,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int PTR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_VOTES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DONE} state_t;

  state_t state, state_next;

  logic [2:0]       hist [WINDOW];
  logic [CNT_W-1:0] counts [8];
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] filled;
  logic [2:0]       cls_q;
  logic [2:0]       scan_idx;
  logic [2:0]       max_cls;
  logic [CNT_W-1:0] max_cnt;

  logic             full;
  logic [2:0]       evicted;
  logic             scan_take;
  logic [2:0]       win_cls;
  logic [CNT_W-1:0] win_cnt;

  assign full      = (filled == WIN_C);
  assign evicted   = hist[wr_ptr];
  assign scan_take = (counts[scan_idx] > max_cnt);
  assign win_cls   = scan_take ? scan_idx : max_cls;
  assign win_cnt   = scan_take ? counts[scan_idx] : max_cnt;
  assign busy      = (state != IDLE);
  assign in_ready  = ~busy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (class_valid) state_next = UPDATE;
      UPDATE:  state_next = SCAN;
      SCAN:    if (scan_idx == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Clear wipes the window statistics but deliberately leaves the last reported result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WINDOW; k++) hist[k] <= '0;
      for (int k = 0; k < 8; k++) counts[k] <= '0;
      wr_ptr      <= '0;
      filled      <= '0;
      cls_q       <= '0;
      scan_idx    <= '0;
      max_cls     <= '0;
      max_cnt     <= '0;
      voted_class <= '0;
      vote_count  <= '0;
      confident   <= 1'b0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < 8; k++) counts[k] <= '0;
      wr_ptr    <= '0;
      filled    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (class_valid && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (class_valid) cls_q <= class_in;
        end
        UPDATE: begin
          // Evicting and adding the same class leaves its count untouched.
          for (int k = 0; k < 8; k++) begin
            if (full && evicted != cls_q) begin
              if (3'(k) == cls_q)        counts[k] <= counts[k] + CNT_W'(1);
              else if (3'(k) == evicted) counts[k] <= counts[k] - CNT_W'(1);
            end else if (!full && 3'(k) == cls_q) begin
              counts[k] <= counts[k] + CNT_W'(1);
            end
          end
          hist[wr_ptr] <= cls_q;
          wr_ptr       <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
          if (!full) filled <= filled + CNT_W'(1);
          scan_idx <= '0;
          max_cls  <= '0;
          max_cnt  <= '0;
        end
        SCAN: begin
          if (scan_take) begin
            max_cnt <= counts[scan_idx];
            max_cls <= scan_idx;
          end
          scan_idx <= scan_idx + 3'd1;
          // Results are registered on the final scan step so they are visible during DONE.
          if (scan_idx == 3'd7 && full) begin
            if (counts[voted_class] != win_cnt) voted_class <= win_cls;
            vote_count <= win_cnt;
            confident  <= (win_cnt >= MIN_C);
            out_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
